// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an internal TX FIFO.
//
// Words written by the host are queued in a small FIFO. Frames go out
// back to back for as long as the FIFO holds data. Each word is copied into
// a shift register when its frame starts, so later host writes cannot
// disturb the frame that is already on the line.
//
// Frame layout: 1 start bit (low), DATA_BITS data bits sent LSB first, an
// optional parity bit, then STOP_BITS stop bits (high). Every bit lasts
// CLK_FRQ/BAUD clock cycles.
//
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   rst        asynchronous reset, active low (0 = reset asserted)
//   axiiv      host data valid
//   axiid      host data word, sent LSB first
//   axiir      ready; high while the FIFO is not full
//   axiod      serial TX line, idles high
//   busy       high while a frame is on the line (start through last stop)
//   done       one-cycle pulse in the cycle after the last stop-bit period
//   fifo_count current FIFO occupancy
//   state_dbg  current FSM state (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//
// Handshake: a word is transferred on a rising edge where axiiv && axiir.
// axiir is a function of the registered occupancy only and never depends on
// axiiv. A host that sees axiir low keeps axiiv and axiid steady until it
// rises again.
module uart_tx_fifo #(
  parameter int CLK_FRQ    = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          axiiv,
  input  logic [DATA_BITS-1:0]          axiid,
  output logic                          axiir,
  output logic                          axiod,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    state_dbg
);

  localparam int CPB   = CLK_FRQ / BAUD;
  // One counter times both single bits and the whole stop period.
  localparam int CNT_W = $clog2(CPB * STOP_BITS) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CPB * STOP_BITS - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [PTR_W:0]   FULL      = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign axiir      = (fifo_count != FULL);
  assign push       = axiiv && axiir;
  assign fifo_empty = (fifo_count == '0);
  assign head       = mem[rd_ptr];

  // Occupancy is kept separately from the pointers. A push and a pop on the
  // same edge leave it unchanged, even when the FIFO is full: the pop frees
  // the slot, but axiir still reflects the pre-edge count, so no push can
  // happen on that edge anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= axiid;
  end

  // ----------------------------------------------------------------- FSM
  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 par_bit, par_n;
  logic                 done_n;
  logic                 last_bit;
  logic                 head_par;

  assign last_bit = (cnt == BIT_LAST);
  // Odd parity makes the total count of ones odd; even makes it even.
  assign head_par = (PARITY == 1) ? ~^head : ^head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      par_bit   <= par_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    par_n     = par_bit;
    done_n    = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = head_par;
          cnt_n   = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (last_bit) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = S_DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (last_bit) begin
          cnt_n   = '0;
          shift_n = shift_reg >> 1;
          if (bit_idx == DATA_LAST) begin
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (last_bit) begin
          cnt_n   = '0;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        // The stop period is timed as one long interval of
        // STOP_BITS * CPB cycles.
        if (cnt == STOP_LAST) begin
          done_n = 1'b1;
          cnt_n  = '0;
          if (!fifo_empty) begin
            // The next frame starts with no idle gap.
            pop     = 1'b1;
            shift_n = head;
            par_n   = head_par;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The line is decoded from registered state, so it goes high at the same
  // moment as an asynchronous reset.
  always_comb begin
    axiod = 1'b1;
    case (state)
      S_START:  axiod = 1'b0;
      S_DATA:   axiod = shift_reg[0];
      S_PARITY: axiod = par_bit;
      default:  axiod = 1'b1;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. Three configurations share the same host stimulus:
//   u0: 8 data bits, no parity,   1 stop bit,  depth 4
//   u1: 8 data bits, even parity, 1 stop bit,  depth 4
//   u2: 7 data bits, odd parity,  2 stop bits, depth 2
// All three run at 10 cycles per bit.
//
// The reference model records when each word is accepted. From that it
// derives when the word's frame starts:
//   start = max(accept edge + 1, end of the previous frame)
// Line level, busy, done and occupancy for any cycle then follow by
// arithmetic. Cycle n is the interval after rising edge n.
module tb_uart_tx_fifo;
  localparam int CPB = 10;
  localparam int NDUT = 3;
  localparam int DB  [NDUT] = '{8, 8, 7};
  localparam int PAR [NDUT] = '{0, 2, 1};
  localparam int SB  [NDUT] = '{1, 1, 2};
  localparam int DEP [NDUT] = '{4, 4, 2};
  localparam int MAXW = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       axiiv = 1'b0;
  logic [7:0] axiid = 8'h00;

  logic       axiir_a [NDUT];
  logic       axiod_a [NDUT];
  logic       busy_a  [NDUT];
  logic       done_a  [NDUT];
  logic [2:0] st_a    [NDUT];
  logic [2:0] cnt0, cnt1;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FRQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiir(axiir_a[0]),
    .axiod(axiod_a[0]), .busy(busy_a[0]), .done(done_a[0]), .fifo_count(cnt0),
    .state_dbg(st_a[0]));

  uart_tx_fifo #(.CLK_FRQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiir(axiir_a[1]),
    .axiod(axiod_a[1]), .busy(busy_a[1]), .done(done_a[1]), .fifo_count(cnt1),
    .state_dbg(st_a[1]));

  uart_tx_fifo #(.CLK_FRQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid[6:0]), .axiir(axiir_a[2]),
    .axiod(axiod_a[2]), .busy(busy_a[2]), .done(done_a[2]), .fifo_count(cnt2),
    .state_dbg(st_a[2]));

  // ------------------------------------------------------------ scoreboard
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int         na [NDUT];
  int         lo [NDUT];
  int         nf [NDUT];
  int         a_e [NDUT][MAXW];
  int         p_e [NDUT][MAXW];
  logic [7:0] w_v [NDUT][MAXW];

  function automatic int get_cnt(input int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic int flen(input int i);
    return CPB * (1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i]);
  endfunction

  function automatic logic frame_bit(input int i, input logic [7:0] w, input int off);
    int ones;
    ones = 0;
    if (off == 0) return 1'b0;
    if (off <= DB[i]) return w[off-1];
    if (PAR[i] != 0 && off == DB[i] + 1) begin
      for (int b = 0; b < DB[i]; b++) ones += int'(w[b]);
      if (PAR[i] == 2) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  function automatic void m_eval(input int i, input int n, output logic line,
                                 output logic bsy, output logic dn, output int cnt);
    line = 1'b1; bsy = 1'b0; dn = 1'b0; cnt = 0;
    for (int k = lo[i]; k < na[i]; k++) begin
      if (a_e[i][k] <= n && n < p_e[i][k]) cnt++;
      if (p_e[i][k] <= n && n < p_e[i][k] + flen(i)) begin
        bsy  = 1'b1;
        line = frame_bit(i, w_v[i][k], (n - p_e[i][k]) / CPB);
      end
      if (p_e[i][k] + flen(i) == n) dn = 1'b1;
    end
  endfunction

  function automatic int m_count(input int i, input int n);
    logic l, b, d;
    int c;
    m_eval(i, n, l, b, d, c);
    return c;
  endfunction

  function automatic bit m_idle(input int i);
    return (nf[i] < cyc) && (m_count(i, cyc) == 0);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NDUT; i++) begin
      na[i] = 0; lo[i] = 0; nf[i] = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_dut(input int i);
    logic el, eb, ed, er;
    int   ec;
    m_eval(i, cyc, el, eb, ed, ec);
    er = (ec != DEP[i]);
    vectors++;
    if (axiod_a[i] !== el || busy_a[i] !== eb || done_a[i] !== ed ||
        get_cnt(i) != ec || axiir_a[i] !== er) begin
      miscompares++;
      $display("FAIL model u%0d cycle %0d: axiod %b/%b busy %b/%b done %b/%b count %0d/%0d ready %b/%b (got/expected)",
               i, cyc, axiod_a[i], el, busy_a[i], eb, done_a[i], ed, get_cnt(i), ec, axiir_a[i], er);
    end
  endtask

  // One clock cycle: decide acceptance from the pre-edge state, cross the
  // edge, log accepted words, then compare every DUT at the falling edge.
  task automatic tick();
    logic       acc [NDUT];
    logic [7:0] d;
    d = axiid;
    for (int i = 0; i < NDUT; i++)
      acc[i] = rst && axiiv && (m_count(i, cyc) != DEP[i]);
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NDUT; i++) begin
      if (acc[i] && na[i] < MAXW) begin
        a_e[i][na[i]] = cyc;
        p_e[i][na[i]] = (cyc + 1 > nf[i]) ? cyc + 1 : nf[i];
        w_v[i][na[i]] = d;
        nf[i] = p_e[i][na[i]] + flen(i);
        na[i]++;
      end
      while (lo[i] < na[i] && p_e[i][lo[i]] + flen(i) < cyc) lo[i]++;
    end
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) check_dut(i);
  endtask

  task automatic tick_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (!(m_idle(0) && m_idle(1) && m_idle(2)) && t < budget) begin
      tick();
      t++;
    end
    chk("wait_idle timeout", int'(t < budget), 1);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [11:0] frame;  // line bits in send order, bit 0 = start bit
    int         nbits;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int s, a0, a5, nd, k0;
    int dcyc [4];
    vec_t v;

    tbl[0] = '{0, 8'hA5, 12'b001101001010, 10};
    tbl[1] = '{1, 8'h07, 12'b011000001110, 11};
    tbl[2] = '{2, 8'h07, 12'b011000001110, 11};
    tbl[3] = '{2, 8'h41, 12'b011110000010, 11};
    tbl[4] = '{0, 8'h3C, 12'b001001111000, 10};
    tbl[5] = '{1, 8'h03, 12'b010000000110, 11};

    // Reset.
    model_clear();
    rst = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("reset axiod u%0d", i), int'(axiod_a[i]), 1);
      chk($sformatf("reset busy u%0d", i), int'(busy_a[i]), 0);
      chk($sformatf("reset done u%0d", i), int'(done_a[i]), 0);
      chk($sformatf("reset ready u%0d", i), int'(axiir_a[i]), 1);
      chk($sformatf("reset count u%0d", i), get_cnt(i), 0);
      chk($sformatf("reset state u%0d", i), int'(st_a[i]), 0);
    end
    rst = 1'b1;
    repeat (2) tick();

    // Table-driven single frames, sampled mid-bit.
    for (int k = 0; k < 6; k++) begin
      v = tbl[k];
      wait_idle(400);
      axiid = v.data;
      axiiv = 1'b1;
      tick();
      axiiv = 1'b0;
      chk($sformatf("tbl%0d line before start", k), int'(axiod_a[v.dut]), 1);
      s = cyc + 1;
      tick();
      chk($sformatf("tbl%0d start low", k), int'(axiod_a[v.dut]), 0);
      chk($sformatf("tbl%0d busy at start", k), int'(busy_a[v.dut]), 1);
      for (int b = 0; b < v.nbits; b++) begin
        tick_until(s + b * CPB + 5);
        chk($sformatf("tbl%0d bit%0d", k, b), int'(axiod_a[v.dut]), int'(v.frame[b]));
      end
      tick_until(s + v.nbits * CPB - 1);
      chk($sformatf("tbl%0d done early", k), int'(done_a[v.dut]), 0);
      tick();
      chk($sformatf("tbl%0d done", k), int'(done_a[v.dut]), 1);
    end

    // Back-to-back pushes on consecutive cycles.
    wait_idle(400);
    a0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      axiid = 8'h11 * (k + 1);
      axiiv = 1'b1;
      chk($sformatf("b2b ready %0d", k), int'(axiir_a[0]), 1);
      tick();
    end
    axiiv = 1'b0;
    chk("b2b count", get_cnt(0), 3);
    nd = 0;
    for (int t = 0; t < 600 && nd < 4; t++) begin
      tick();
      if (done_a[0]) begin
        dcyc[nd] = cyc;
        nd++;
      end
    end
    chk("b2b done pulses", nd, 4);
    chk("b2b first done", dcyc[0], a0 + 1 + 100);
    for (int k = 1; k < 4; k++)
      chk($sformatf("b2b done spacing %0d", k), dcyc[k] - dcyc[k-1], 100);
    wait_idle(1200);

    // Full / stall: a frame in flight, then five more words held until taken.
    axiid = 8'h80;
    axiiv = 1'b1;
    tick();
    axiiv = 1'b0;
    a0 = cyc;
    a5 = 0;
    for (int k = 0; k < 5; k++) begin
      axiid = 8'h90 + 8'(k);
      axiiv = 1'b1;
      if (k == 4) begin
        chk("full count", get_cnt(0), 4);
        chk("full ready", int'(axiir_a[0]), 0);
      end
      k0 = na[0];
      for (int t = 0; t < 300 && na[0] == k0; t++) tick();
      chk($sformatf("stall accept %0d", k), na[0] - k0, 1);
      if (k == 4) a5 = cyc;
    end
    axiiv = 1'b0;
    chk("fifth accept edge", a5, a0 + 1 + 100 + 1);
    wait_idle(2500);

    // Reset in the middle of the 4th data bit.
    axiid = 8'h5A;
    axiiv = 1'b1;
    tick();
    axiiv = 1'b0;
    s = cyc + 1;
    tick_until(s + 44);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("async reset axiod u%0d", i), int'(axiod_a[i]), 1);
      chk($sformatf("async reset busy u%0d", i), int'(busy_a[i]), 0);
      chk($sformatf("async reset count u%0d", i), get_cnt(i), 0);
    end
    model_clear();
    repeat (3) tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("no residual frame", int'(busy_a[0]), 0);
    axiid = 8'hC3;
    axiiv = 1'b1;
    tick();
    axiiv = 1'b0;
    wait_idle(400);

    // Random traffic, every cycle checked against the model.
    for (int t = 0; t < 3000; t++) begin
      axiiv = ($urandom_range(0, 99) < 15);
      axiid = 8'($urandom);
      tick();
    end
    axiiv = 1'b0;
    wait_idle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
